// File: rtl/flag_cond_eval.sv
// flag_cond_eval: evaluates a condition code against the flag word and returns a taken/not-taken result
module flag_cond_eval (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] flags,
    input  logic       req_valid,
    input  logic [3:0] req_cond,
    input  logic       req_clr,
    output logic       req_ready,
    output logic       resp_valid,
    output logic       resp_taken,
    input  logic       resp_ready,
    output logic       flag_clr_en,
    output logic [7:0] flag_clr_mask,
    output logic [7:0] taken_count
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    state_t     state;
    logic [3:0] cond_q;
    logic       clr_q;
    logic       z, n, c, v;
    logic       taken;
    logic [7:0] mask;
    assign z = flags[0];
    assign n = flags[1];
    assign c = flags[2];
    assign v = flags[3];
    assign req_ready = (state == IDLE);
    // condition result from the live flag word, only consumed in EVAL
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            4'd0:  taken = z;
            4'd1:  taken = !z;
            4'd2:  taken = c;
            4'd3:  taken = !c;
            4'd4:  taken = n;
            4'd5:  taken = !n;
            4'd6:  taken = v;
            4'd7:  taken = !v;
            4'd8:  taken = c & !z;
            4'd9:  taken = !c | z;
            4'd10: taken = (n == v);
            4'd11: taken = (n != v);
            4'd12: taken = !z & (n == v);
            4'd13: taken = z | (n != v);
            4'd14: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
    // flags tested by each condition pair (Z=01, N=02, C=04, V=08)
    always_comb begin
        mask = (cond_q[3:1] == 3'd0) ? 8'h01 :
               (cond_q[3:1] == 3'd1) ? 8'h04 :
               (cond_q[3:1] == 3'd2) ? 8'h02 :
               (cond_q[3:1] == 3'd3) ? 8'h08 :
               (cond_q[3:1] == 3'd4) ? 8'h05 :
               (cond_q[3:1] == 3'd5) ? 8'h0A :
               (cond_q[3:1] == 3'd6) ? 8'h0B : 8'h00;
    end
    // request/evaluate/respond sequencer with registered outputs and saturating taken counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cond_q        <= 4'd0;
            clr_q         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_taken    <= 1'b0;
            flag_clr_en   <= 1'b0;
            flag_clr_mask <= 8'h00;
            taken_count   <= 8'h00;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state  <= EVAL;
                    cond_q <= req_cond;
                    clr_q  <= req_clr;
                end
                EVAL: begin
                    state         <= RESP;
                    resp_valid    <= 1'b1;
                    resp_taken    <= taken;
                    flag_clr_en   <= clr_q & taken & (mask != 8'h00);
                    flag_clr_mask <= (clr_q & taken) ? mask : 8'h00;
                end
                RESP: begin
                    flag_clr_en   <= 1'b0;
                    flag_clr_mask <= 8'h00;
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_taken <= 1'b0;
                        if (resp_taken && taken_count != 8'hFF)
                            taken_count <= taken_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flag_cond_eval.sv
// tb_flag_cond_eval: directed scoreboard bench for flag_cond_eval
module tb_flag_cond_eval;
    logic       clk = 0;
    logic       reset;
    logic [7:0] flags;
    logic       req_valid;
    logic [3:0] req_cond;
    logic       req_clr;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_taken;
    logic       resp_ready;
    logic       flag_clr_en;
    logic [7:0] flag_clr_mask;
    logic [7:0] taken_count;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] sb[$];
    logic [7:0] exp_cnt = 0;
    logic       last_taken;

    flag_cond_eval dut (
        .clk(clk), .reset(reset), .flags(flags), .req_valid(req_valid),
        .req_cond(req_cond), .req_clr(req_clr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_ready(resp_ready),
        .flag_clr_en(flag_clr_en), .flag_clr_mask(flag_clr_mask), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    function automatic logic model_taken(input logic [3:0] cc, input logic [7:0] f);
        logic z, n, c, v, b;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        case (cc[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c && !z;
            3'd5: b = !(n ^ v);
            3'd6: b = !z && !(n ^ v);
            default: b = 1'b1;
        endcase
        return cc[0] ? !b : b;
    endfunction

    function automatic logic [7:0] model_mask(input logic [3:0] cc);
        case (cc[3:1])
            3'd0: return 8'h01;
            3'd1: return 8'h04;
            3'd2: return 8'h02;
            3'd3: return 8'h08;
            3'd4: return 8'h05;
            3'd5: return 8'h0A;
            3'd6: return 8'h0B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] cc, input logic cl, input logic [7:0] f);
        int lat;
        logic [9:0] e;
        logic t;
        logic [7:0] m;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_cond = cc; req_clr = cl; flags = f;
        t = model_taken(cc, f);
        m = model_mask(cc);
        sb.push_back({t, cl && t && m != 0, (cl && t) ? m : 8'h00});
        @(posedge clk);
        #1 req_valid = 0; req_cond = 4'($urandom); req_clr = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 8);
        chk("latency", lat, 2);
        e = sb.pop_front();
        last_taken = e[9];
        chk("resp_taken", resp_taken, e[9]);
        chk("clr_en", flag_clr_en, e[8]);
        chk("clr_mask", flag_clr_mask, e[7:0]);
        chk("req_ready_resp", req_ready, 0);
    endtask

    task automatic finish_resp();
        resp_ready = 1;
        @(posedge clk);
        if (last_taken && exp_cnt != 8'hFF) exp_cnt++;
        @(negedge clk);
        chk("resp_valid_done", resp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("clr_en_after", flag_clr_en, 0);
        chk("taken_count", taken_count, exp_cnt);
    endtask

    initial begin
        reset = 1; flags = 0; req_valid = 0; req_cond = 0; req_clr = 0; resp_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_taken", resp_taken, 0);
        chk("rst_clr_en", flag_clr_en, 0);
        chk("rst_clr_mask", flag_clr_mask, 0);
        chk("rst_count", taken_count, 0);
        reset = 0;
        issue(4'd0, 0, 8'h01);
        finish_resp();
        for (int i = 10; i < 14; i++) begin
            issue(4'(i), 0, 8'h0A);
            finish_resp();
        end
        issue(4'd12, 0, 8'h0B); finish_resp();
        issue(4'd13, 0, 8'h0B); finish_resp();
        foreach (sb[i]) chk("sb_empty", 1, 0);
        resp_ready = 0;
        issue(4'd8, 1, 8'h04);
        @(negedge clk);
        chk("hi_pulse_gone", flag_clr_en, 0);
        chk("hi_mask_gone", flag_clr_mask, 0);
        chk("hi_hold_valid", resp_valid, 1);
        finish_resp();
        resp_ready = 0;
        issue(4'd8, 1, 8'h05);
        @(negedge clk);
        chk("hi_nt_no_pulse", flag_clr_en, 0);
        finish_resp();
        resp_ready = 0;
        issue(4'd0, 0, 8'h01);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 flags = 8'($urandom); req_valid = 1;
            @(negedge clk);
            chk("stall_valid", resp_valid, 1);
            chk("stall_taken", resp_taken, last_taken);
            chk("stall_ready", req_ready, 0);
        end
        req_valid = 0;
        finish_resp();
        for (int i = 0; i < 16; i++) begin
            issue(4'(i), 1'(i % 3 != 0), 8'($urandom));
            finish_resp();
        end
        for (int i = 0; i < 300; i++) begin
            issue(4'd14, 0, 8'($urandom));
            finish_resp();
        end
        chk("saturated", taken_count, 8'hFF);
        issue(4'd15, 1, 8'hFF); finish_resp();
        chk("nv_unchanged", taken_count, 8'hFF);
        @(negedge clk);
        req_valid = 1; req_cond = 4'd14; req_clr = 1; flags = 8'h0F;
        @(posedge clk);
        #1 req_valid = 0; reset = 1;
        #1 chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_count", taken_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_valid", resp_valid, 0);
            chk("rst_mid_clr", flag_clr_en, 0);
        end
        reset = 0;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", resp_valid, 0);
            chk("post_rst_ready", req_ready, 1);
        end
        issue(4'd0, 0, 8'h01); finish_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/flag_cond_eval.md
# flag_cond_eval

Consumer-side companion to the processor flag register. It accepts branch/condition requests over a valid/ready handshake and samples the 8-bit flag word one cycle after acceptance. It evaluates one of 16 condition codes, returns a taken/not-taken result over a second valid/ready handshake, and can optionally request that the tested flags be cleared. It sits between the flag register output and the control/branch logic.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flags  in  8  flag word from the flag register: bit0 Z, bit1 N, bit2 C, bit3 V, bits 7:4 unused here.
- req_valid  in  1  request present.
- req_cond  in  4  condition code; held in the block once accepted.
- req_clr  in  1  clear tested flags if the condition evaluates true.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  result present.
- resp_taken  out  1  condition result; meaningful only while resp_valid is high.
- resp_ready  in  1  consumer accepts the result.
- flag_clr_en  out  1  one-cycle pulse requesting a flag clear.
- flag_clr_mask  out  8  flags to clear; meaningful only while flag_clr_en is high.
- taken_count  out  8  saturating count of taken results delivered.

## Operation
- FSM states and transitions:
  - IDLE → EVAL on req_valid && req_ready. req_cond and req_clr are latched on this edge.
  - EVAL → RESP unconditionally. flags are sampled and evaluated in EVAL, and the result is registered into resp_taken on the EVAL→RESP edge.
  - RESP → IDLE on resp_valid && resp_ready.
  - RESP holds with resp_taken stable while resp_ready is low.
- Condition codes (Z, N, C, V taken from the flags sampled in EVAL):
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- Clear masks by code:
  - 0/1 → 0x01.
  - 4/5 → 0x02.
  - 2/3 → 0x04.
  - 6/7 → 0x08.
  - 8/9 → 0x05.
  - 10/11 → 0x0A.
  - 12/13 → 0x0B.
  - 14/15 → 0x00.
- flag_clr_en:
  - High for exactly the first RESP cycle, and only if the latched req_clr=1, the result is taken, and the mask is nonzero.
  - flag_clr_mask carries the mask in that cycle and is 0x00 otherwise.
  - The pulse is independent of resp_ready.
- taken_count increments by 1 on each response handshake with resp_taken=1. It saturates at 0xFF with no wrap.
- flags bits 7:4 never affect evaluation or masks.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE, so req_ready=1.
  - resp_valid=0, resp_taken=0.
  - flag_clr_en=0, flag_clr_mask=0x00.
  - taken_count=0x00.
  - Latched request cleared.
- Latency:
  - Accept at edge T; flags sampled during cycle T+1 (EVAL).
  - resp_valid=1 from cycle T+2.
  - A flag-register write landing on edge T+1 is visible to the evaluation.
- Throughput:
  - Best case is one request per 3 cycles.
  - Handshake at edge R gives req_ready=1 in cycle R+1.
  - req_ready is never high in the same cycle as resp_valid.
- Backpressure: resp_taken and resp_valid hold indefinitely while resp_ready=0. flags changing during RESP has no effect on resp_taken.
- req_valid while not ready is ignored and produces no side effects. resp_ready while resp_valid=0 is ignored.
- Reset mid-operation (EVAL or RESP):
  - Response dropped.
  - No flag_clr_en pulse.
  - Counter cleared.
  - Outputs at reset values in the same cycle reset asserts.

## Test plan
- Reset released, flags=0x01, req cond=0 (EQ), resp_ready=1:
  - Response 2 cycles after accept with resp_taken=1.
  - taken_count=1.
  - req_ready back high one cycle after the response handshake.
- flags=0x0A (N=1, V=1), sweep codes 10–13:
  - GE=1, LT=0, GT=1, LE=0.
  - Then flags=0x0B: GT=0, LE=1.
- req_clr=1, cond=8 (HI), flags=0x04:
  - resp_taken=1.
  - flag_clr_en pulses once with mask 0x05 in the first RESP cycle.
  - Repeat with flags=0x05: taken=0, no pulse.
- resp_ready held low 5 cycles while flags toggle:
  - resp_valid and resp_taken stable.
  - req_ready=0 throughout.
  - No second accept despite req_valid=1.
- 300 AL requests with resp_ready=1: taken_count saturates at 0xFF. NV requests leave the counter unchanged.
- Assert reset in the EVAL cycle: resp_valid never rises, flag_clr_en stays 0, and req_ready=1 after release.
